// File: rtl/dp_arbiter.sv
// Two-requester round-robin front end for a shared dot-product engine.
// A winner's operands are latched and the engine is restarted (LOAD), the
// engine result is awaited with a timeout (RUN), and the winner gets a done
// pulse together with the registered result and timeout flag (DONE).
module dp_arbiter #(
  parameter int VECTOR_SIZE = 4,
  parameter int DATA_WIDTH  = 31,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [DATA_WIDTH-1:0] r0_vec1 [0:VECTOR_SIZE-1],
  input  logic [DATA_WIDTH-1:0] r0_vec2 [0:VECTOR_SIZE-1],
  input  logic [DATA_WIDTH-1:0] r1_vec1 [0:VECTOR_SIZE-1],
  input  logic [DATA_WIDTH-1:0] r1_vec2 [0:VECTOR_SIZE-1],
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err,
  output logic                  eng_reset,
  output logic [DATA_WIDTH-1:0] eng_vec1 [0:VECTOR_SIZE-1],
  output logic [DATA_WIDTH-1:0] eng_vec2 [0:VECTOR_SIZE-1],
  input  logic                  eng_valid,
  input  logic [DATA_WIDTH-1:0] eng_result
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  state_t                state_q, state_d;
  logic                  win_q, win_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            done_q, done_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;
  logic                  eng_reset_q, eng_reset_d;
  logic [DATA_WIDTH-1:0] vec1_q [0:VECTOR_SIZE-1];
  logic [DATA_WIDTH-1:0] vec2_q [0:VECTOR_SIZE-1];
  logic [DATA_WIDTH-1:0] vec1_d [0:VECTOR_SIZE-1];
  logic [DATA_WIDTH-1:0] vec2_d [0:VECTOR_SIZE-1];
  logic                  timeout_s;

  assign timeout_s = (cnt_q == CW'(TIMEOUT - 1));

  // State and registered-output storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      win_q       <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      result_q    <= '0;
      err_q       <= 1'b0;
      eng_reset_q <= 1'b1;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        vec1_q[i] <= '0;
        vec2_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      err_q       <= err_d;
      eng_reset_q <= eng_reset_d;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        vec1_q[i] <= vec1_d[i];
        vec2_q[i] <= vec2_d[i];
      end
    end
  end

  // Next state and round-robin winner selection; requests only count in IDLE.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d = S_LOAD;
          win_d   = (req == 2'b11) ? ~last_q : req[1];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (eng_valid || timeout_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and priority pointer.
  always_comb begin
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    result_d    = result_q;
    err_d       = err_q;
    eng_reset_d = 1'b0;
    cnt_d       = cnt_q;
    last_d      = last_q;
    vec1_d      = vec1_q;
    vec2_d      = vec2_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // Entering LOAD: grant, restart the engine, capture the winner's operands.
          gnt_d       = win_d ? 2'b10 : 2'b01;
          eng_reset_d = 1'b1;
          for (int i = 0; i < VECTOR_SIZE; i++) begin
            vec1_d[i] = win_d ? r1_vec1[i] : r0_vec1[i];
            vec2_d[i] = win_d ? r1_vec2[i] : r0_vec2[i];
          end
        end else begin
          eng_reset_d = 1'b0;
        end
      end
      S_LOAD: cnt_d = '0;
      S_RUN: begin
        if (eng_valid) begin
          result_d = eng_result;
          err_d    = 1'b0;
          done_d   = win_q ? 2'b10 : 2'b01;
        end else if (timeout_s) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = win_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  last_d = win_q;
      default: cnt_d = '0;
    endcase
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign eng_reset = eng_reset_q;
  assign eng_vec1  = vec1_q;
  assign eng_vec2  = vec2_q;

endmodule

// File: tb/tb_dp_arbiter.sv
// Scoreboard bench for dp_arbiter with a behavioural engine responder.
module tb_dp_arbiter;
  localparam int VS = 4;
  localparam int DW = 31;
  localparam int TO = 8;

  typedef struct {
    logic [1:0]    who;
    logic [DW-1:0] res;
    logic          err;
    int            diff;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [DW-1:0] r0v1 [0:VS-1];
  logic [DW-1:0] r0v2 [0:VS-1];
  logic [DW-1:0] r1v1 [0:VS-1];
  logic [DW-1:0] r1v2 [0:VS-1];
  logic [1:0]    gnt, done;
  logic [DW-1:0] result;
  logic          err, eng_reset;
  logic [DW-1:0] eng_vec1 [0:VS-1];
  logic [DW-1:0] eng_vec2 [0:VS-1];
  logic          eng_valid = 1'b0;
  logic [DW-1:0] eng_result = '0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   done_seen = 0;
  int   eng_lat = 3;
  int   ecnt = 0;
  bit   armed = 1'b0;
  bit   spur = 1'b0;
  logic model_last = 1'b1;
  logic [1:0] exp_gnt_q [$];
  exp_t exp_done_q [$];

  dp_arbiter #(.VECTOR_SIZE(VS), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .r0_vec1(r0v1), .r0_vec2(r0v2), .r1_vec1(r1v1), .r1_vec2(r1v2),
    .gnt(gnt), .done(done), .result(result), .err(err), .eng_reset(eng_reset),
    .eng_vec1(eng_vec1), .eng_vec2(eng_vec2),
    .eng_valid(eng_valid), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] dot(input logic [DW-1:0] a [VS], input logic [DW-1:0] b [VS]);
    longint s = 0;
    for (int i = 0; i < VS; i++) s += longint'(a[i]) * longint'(b[i]);
    return DW'(s);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine responder: after a restart pulse, answers on RUN cycle eng_lat.
  initial forever begin
    @(negedge clk);
    if (!reset || eng_reset) begin
      armed      = reset && eng_reset;
      ecnt       = 0;
      eng_valid  = spur;
      eng_result = spur ? DW'(123) : '0;
    end else begin
      eng_valid  = (armed && ecnt == eng_lat) || spur;
      eng_result = spur ? DW'(123) : dot(eng_vec1, eng_vec2);
      if (armed && ecnt == eng_lat) armed = 1'b0;
      if (armed) ecnt++;
    end
  end

  // Monitor: pops expectations whenever the DUT shows a grant or a done pulse.
  initial forever begin
    @(negedge clk);
    if (gnt != 2'b00) begin
      gnt_cyc = cyc;
      if (exp_gnt_q.size() == 0) chk("unexpected_gnt", {62'd0, gnt}, 64'd0);
      else chk("gnt_order", {62'd0, gnt}, {62'd0, exp_gnt_q.pop_front()});
    end
    if (done != 2'b00) begin
      done_seen++;
      if (exp_done_q.size() == 0) begin
        chk("unexpected_done", {62'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = exp_done_q.pop_front();
        chk("done_who", {62'd0, done}, {62'd0, e.who});
        chk("result", {33'd0, result}, {33'd0, e.res});
        chk("err", {63'd0, err}, {63'd0, e.err});
        chk("gnt_to_done", 64'(cyc - gnt_cyc), 64'(e.diff));
      end
    end
  end

  // Reference model: service order and outcome of a request pattern.
  task automatic predict(input logic [1:0] r, input int lat);
    logic w [$];
    if (r == 2'b11) begin
      w.push_back(~model_last);
      w.push_back(model_last);
    end else begin
      w.push_back(r[1]);
    end
    foreach (w[j]) begin
      exp_t e;
      e.who  = w[j] ? 2'b10 : 2'b01;
      e.res  = (lat < TO) ? (w[j] ? dot(r1v1, r1v2) : dot(r0v1, r0v2)) : '0;
      e.err  = (lat < TO) ? 1'b0 : 1'b1;
      e.diff = (lat < TO) ? 2 + lat : 2 + TO - 1;
      exp_gnt_q.push_back(e.who);
      exp_done_q.push_back(e);
      model_last = w[j];
    end
  endtask

  task automatic do_req(input logic [1:0] r, input int lat, input bit chk_lat);
    int target;
    bit ok = 1'b0;
    if (chk_lat) @(negedge clk);
    eng_lat = lat;
    target  = done_seen + ((r == 2'b11) ? 2 : 1);
    predict(r, lat);
    req = r;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0 && chk_lat)
        chk("gnt_latency", {62'd0, gnt}, (r == 2'b10 || (r == 2'b11 && model_last == 1'b0)) ? 64'd2 : 64'd1);
      if (gnt[0]) req[0] = 1'b0;
      if (gnt[1]) req[1] = 1'b0;
      if (done_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("job_timeout", 64'd0, 64'd1);
    req = 2'b00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, {62'd0, gnt}, 64'd0);
    chk({tag, "_done"}, {62'd0, done}, 64'd0);
    chk({tag, "_result"}, {33'd0, result}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_eng_reset"}, {63'd0, eng_reset}, 64'd1);
    for (int i = 0; i < VS; i++) begin
      chk({tag, "_vec1"}, {33'd0, eng_vec1[i]}, 64'd0);
      chk({tag, "_vec2"}, {33'd0, eng_vec2[i]}, 64'd0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_gnt_q.delete();
    exp_done_q.delete();
    model_last = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < VS; i++) begin
      r0v1[i] = DW'(i + 1);
      r0v2[i] = DW'(i + 5);
      r1v1[i] = DW'(2);
      r1v2[i] = DW'(1);
    end
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;

    // Single job, engine answers on RUN cycle 3: gnt next cycle, result 70.
    do_req(2'b01, 3, 1'b1);

    // Simultaneous requests right after reset: requester 0 first, then 1.
    pulse_reset();
    do_req(2'b11, 3, 1'b1);

    // Fairness: both re-request immediately for six jobs.
    for (int k = 0; k < 3; k++) do_req(2'b11, int'($urandom_range(0, 4)), 1'b0);

    // Timeout followed by a successful job.
    do_req(2'b01, 100, 1'b1);
    do_req(2'b01, 3, 1'b1);

    // Spurious engine valid while idle must not disturb the held result.
    @(negedge clk);
    spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("spur_result", {33'd0, result}, 64'd70);
      chk("spur_done", {62'd0, done}, 64'd0);
    end
    spur = 1'b0;

    // Reset in the middle of RUN aborts the job without a done pulse.
    @(negedge clk);
    eng_lat = 50;
    exp_gnt_q.push_back(2'b01);
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_done_q.delete();
    model_last = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrun");
    reset = 1'b1;
    repeat (10) @(negedge clk);
    do_req(2'b01, 3, 1'b1);

    // Randomized jobs with random operands, patterns and engine latency.
    for (int k = 0; k < 20; k++) begin
      logic [1:0] r;
      for (int i = 0; i < VS; i++) begin
        r0v1[i] = DW'($urandom);
        r0v2[i] = DW'($urandom);
        r1v1[i] = DW'($urandom_range(0, 1000));
        r1v2[i] = DW'($urandom_range(0, 1000));
      end
      r = 2'($urandom_range(1, 3));
      do_req(r, int'($urandom_range(0, TO + 2)), 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_gnt_q.size() + exp_done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
